// File: rtl/prot_sequencer_if.sv
// prot_sequencer_if: fault inputs, DSP controls and status outputs of the protection sequencer.
// PRT_SEQ_FLT_MASK_EN adds the per-channel flt_mask input.
interface prot_sequencer_if #(
   parameter int N_FLT     = 4,
   parameter int RETRY_MAX = 3
);
   logic [N_FLT-1:0]                   Prt_dly;
   logic                               start;
   logic                               clr;
`ifdef PRT_SEQ_FLT_MASK_EN
   logic [N_FLT-1:0]                   flt_mask;
`endif
   logic                               pwm_en;
   logic [N_FLT-1:0]                   first_flt;
   logic [$clog2(RETRY_MAX+1)-1:0]     retry_cnt;
   logic                               lockout;
   logic [2:0]                         state;
`ifdef PRT_SEQ_FLT_MASK_EN
   modport master (output Prt_dly, start, clr, flt_mask,
                   input pwm_en, first_flt, retry_cnt, lockout, state);
   modport slave  (input Prt_dly, start, clr, flt_mask,
                   output pwm_en, first_flt, retry_cnt, lockout, state);
`else
   modport master (output Prt_dly, start, clr,
                   input pwm_en, first_flt, retry_cnt, lockout, state);
   modport slave  (input Prt_dly, start, clr,
                   output pwm_en, first_flt, retry_cnt, lockout, state);
`endif
endinterface

// File: rtl/prot_sequencer.sv
// prot_sequencer: fault aggregation, PWM gating, cool-down/auto-retry and lockout for the LLC power stage.
// PRT_SEQ_FLT_MASK_EN enables masking of individual fault channels.
module prot_sequencer #(
   parameter int N_FLT      = 4,
   parameter int COOL_CYC   = 200,
   parameter int RETRY_MAX  = 3,
   parameter int RUN_OK_CYC = 1000
) (
   input logic              clk,
   input logic              Rst,
   prot_sequencer_if.slave  bus
);
   localparam int RW  = $clog2(RETRY_MAX+1);
   localparam int RTW = $clog2(RUN_OK_CYC)+1;
   localparam int CTW = $clog2(COOL_CYC)+1;
   localparam logic [RW-1:0]  RMAX    = RW'(RETRY_MAX);
   localparam logic [RTW-1:0] RUN_OK  = RTW'(RUN_OK_CYC);
   localparam logic [CTW-1:0] COOL_TM = CTW'(COOL_CYC-1);

   typedef enum logic [2:0] {IDLE = 3'd0, RUN = 3'd1, TRIP = 3'd2, COOL = 3'd3, LOCK = 3'd4} state_t;

   state_t           state_q, state_d;
   logic [N_FLT-1:0] fv, first_q, first_d;
   logic [RW-1:0]    retry_q, retry_d;
   logic [RTW-1:0]   run_q, run_d;
   logic [CTW-1:0]   cool_q, cool_d;
   logic             lock_q, lock_d, pwm_q, flt;

`ifdef PRT_SEQ_FLT_MASK_EN
   assign fv = bus.Prt_dly & ~bus.flt_mask;
`else
   assign fv = bus.Prt_dly;
`endif
   assign flt = |fv;

   always_comb begin
      state_d = state_q;
      first_d = first_q;
      retry_d = retry_q;
      run_d   = '0;
      cool_d  = cool_q;
      lock_d  = lock_q;
      case (state_q)
         IDLE: begin
            if (bus.clr) first_d = '0;
            if (bus.start && !flt) state_d = RUN;
         end
         RUN: begin
            if (flt) begin
               state_d = TRIP;
               first_d = fv;
            end else if (!bus.start) begin
               state_d = IDLE;
            end else begin
               run_d = (run_q == RUN_OK) ? run_q : run_q + 1'b1;
               if (run_q == RUN_OK - 1'b1) retry_d = '0;
            end
         end
         TRIP: begin
            if (retry_q == RMAX) begin
               state_d = LOCK;
               lock_d  = 1'b1;
            end else begin
               state_d = COOL;
               retry_d = retry_q + 1'b1;
               cool_d  = '0;
            end
         end
         COOL: begin
            // a fault still present at the end of cool-down holds the retry off
            if (!bus.start) state_d = IDLE;
            else if (cool_q != COOL_TM) cool_d = cool_q + 1'b1;
            else if (!flt) state_d = RUN;
         end
         LOCK: begin
            if (bus.clr && !flt) begin
               state_d = IDLE;
               lock_d  = 1'b0;
               retry_d = '0;
               first_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (Rst) begin
         state_q <= IDLE;
         first_q <= '0;
         retry_q <= '0;
         run_q   <= '0;
         cool_q  <= '0;
         lock_q  <= 1'b0;
         pwm_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         first_q <= first_d;
         retry_q <= retry_d;
         run_q   <= run_d;
         cool_q  <= cool_d;
         lock_q  <= lock_d;
         pwm_q   <= (state_d == RUN);
      end
   end

   assign bus.state     = state_q;
   assign bus.pwm_en    = pwm_q;
   assign bus.first_flt = first_q;
   assign bus.retry_cnt = retry_q;
   assign bus.lockout   = lock_q;
endmodule

// File: tb/tb_prot_sequencer.sv
// tb_prot_sequencer: directed self-checking bench for prot_sequencer (COOL_CYC=20, RETRY_MAX=2, RUN_OK_CYC=50).
module tb_prot_sequencer;
   logic clk = 1'b0;
   logic Rst;
   int   checks = 0;
   int   failures = 0;

   prot_sequencer_if #(.N_FLT(4), .RETRY_MAX(2)) b ();
   prot_sequencer #(.N_FLT(4), .COOL_CYC(20), .RETRY_MAX(2), .RUN_OK_CYC(50)) dut (
      .clk(clk), .Rst(Rst), .bus(b));

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int st, input int pwm, input int ff,
                          input int rc, input int lk);
      chk({tag, ".state"}, 32'(b.state), st);
      chk({tag, ".pwm_en"}, 32'(b.pwm_en), pwm);
      chk({tag, ".first_flt"}, 32'(b.first_flt), ff);
      chk({tag, ".retry_cnt"}, 32'(b.retry_cnt), rc);
      chk({tag, ".lockout"}, 32'(b.lockout), lk);
   endtask

   initial begin
      Rst = 1'b1;
      b.start = 1'b0;
      b.clr = 1'b0;
      b.Prt_dly = 4'b0000;
`ifdef PRT_SEQ_FLT_MASK_EN
      b.flt_mask = 4'b0000;
`endif
      tick(3);
      chk_all("reset", 0, 0, 0, 0, 0);
      Rst = 1'b0;
      b.start = 1'b1;
      tick();
      chk_all("start_run", 1, 1, 0, 0, 0);
      tick(3);
      b.Prt_dly = 4'b0101;
      tick();
      chk_all("trip1", 2, 0, 4'b0101, 0, 0);
      b.Prt_dly = 4'b0000;
      tick();
      chk_all("cool1_entry", 3, 0, 4'b0101, 1, 0);
      tick(19);
      chk("cool1_c19", 32'(b.state), 3);
      tick();
      chk_all("retry1_run", 1, 1, 4'b0101, 1, 0);
      b.Prt_dly = 4'b0100;
      tick();
      chk_all("trip2", 2, 0, 4'b0100, 1, 0);
      tick();
      chk_all("cool2_entry", 3, 0, 4'b0100, 2, 0);
      tick(34);
      chk("cool2_held_flt", 32'(b.state), 3);
      b.Prt_dly = 4'b0000;
      tick();
      chk_all("retry2_run", 1, 1, 4'b0100, 2, 0);
      tick(5);
      b.Prt_dly = 4'b0001;
      tick();
      chk_all("trip3", 2, 0, 4'b0001, 2, 0);
      tick();
      chk_all("lock", 4, 0, 4'b0001, 2, 1);
      b.clr = 1'b1;
      tick();
      chk_all("lock_clr_flt", 4, 0, 4'b0001, 2, 1);
      b.Prt_dly = 4'b0000;
      tick();
      chk_all("lock_exit", 0, 0, 0, 0, 0);
      b.clr = 1'b0;
      tick();
      chk_all("rerun", 1, 1, 0, 0, 0);
      b.Prt_dly = 4'b1000;
      tick();
      b.Prt_dly = 4'b0000;
      tick();
      chk("cool3_retry", 32'(b.retry_cnt), 1);
      tick(20);
      chk("retry3_run", 32'(b.state), 1);
      tick(49);
      chk("run_49_retry", 32'(b.retry_cnt), 1);
      tick();
      chk("run_50_retry", 32'(b.retry_cnt), 0);
      chk("run_50_state", 32'(b.state), 1);
      b.Prt_dly = 4'b0010;
      tick();
      b.Prt_dly = 4'b0000;
      tick();
      chk_all("trip_after_ok", 3, 0, 4'b0010, 1, 0);
      tick(20);
      chk("retry4_run", 32'(b.state), 1);
      b.Prt_dly = 4'b0010;
      b.start = 1'b0;
      tick();
      chk_all("flt_beats_stop", 2, 0, 4'b0010, 1, 0);
      b.Prt_dly = 4'b0000;
      b.start = 1'b1;
      tick();
      chk_all("cool5_entry", 3, 0, 4'b0010, 2, 0);
      tick(4);
      Rst = 1'b1;
      tick();
      chk_all("rst_in_cool", 0, 0, 0, 0, 0);
      Rst = 1'b0;
      b.Prt_dly = 4'b0001;
      tick();
      chk("idle_start_flt", 32'(b.state), 0);
      b.Prt_dly = 4'b0000;
      tick();
      chk("idle_start_ok", 32'(b.state), 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/prot_sequencer.md
Name: prot_sequencer

Overview:
- Protection sequencer for the LLC power stage. It sits downstream of the per-channel protect-delay filters and upstream of the PWM gate enable.
- It aggregates N debounced fault flags and gates PWM on any fault. It captures which fault(s) tripped first.
- It runs a cool-down/auto-retry schedule. After RETRY_MAX consecutive failed retries it latches a lockout that only the DSP can clear.

Parameters:
N_FLT, 4, number of debounced fault inputs
COOL_CYC, 200, clk cycles spent in cool-down before a retry is allowed
RETRY_MAX, 3, retries permitted before lockout
RUN_OK_CYC, 1000, consecutive fault-free RUN cycles that reset retry_cnt to 0

Ports:
clk  in  1  system clock
Rst  in  1  synchronous reset, active-high
Prt_dly  in  N_FLT  debounced fault flags, active-high, synchronous to clk
start  in  1  DSP run request, level
clr  in  1  DSP lockout/fault-record clear, level
pwm_en  out  1  gate enable to PWM stage
first_flt  out  N_FLT  fault vector captured at most recent trip
retry_cnt  out  $clog2(RETRY_MAX+1)  retries consumed
lockout  out  1  latched lockout
state  out  3  IDLE=0, RUN=1, TRIP=2, COOL=3, LOCK=4

Behaviour:
- Interface: one clock (clk); synchronous active-high reset (Rst).
- Reset: state=IDLE, pwm_en=0, first_flt=0, retry_cnt=0, lockout=0, all timers 0. Rst asserted mid-operation forces this on the next edge regardless of state.
- All outputs are registered. pwm_en = (state==RUN) and changes on the same edge as state.
- flt = |Prt_dly.

State transitions:
- IDLE:
  - start & !flt -> RUN.
  - start & flt -> stay in IDLE.
  - clr -> first_flt=0.
- RUN:
  - flt -> TRIP. first_flt <= Prt_dly, all simultaneous bits, captured on that edge. pwm_en is therefore low 1 cycle after fault sampling.
  - else !start -> IDLE. Fault has priority over !start.
  - run_timer increments each RUN cycle, saturating at RUN_OK_CYC. On reaching RUN_OK_CYC, retry_cnt <= 0.
  - run_timer clears on leaving RUN.
- TRIP: lasts exactly 1 cycle.
  - retry_cnt==RETRY_MAX -> LOCK, lockout<=1.
  - else retry_cnt<=retry_cnt+1, -> COOL, cool_timer<=0.
- COOL:
  - cool_timer increments to COOL_CYC-1 and holds there.
  - On the terminal cycle with !flt & start -> RUN.
  - Terminal cycle with flt -> remain in COOL; the retry is deferred until flt clears.
  - !start at any cycle -> IDLE. retry_cnt and first_flt are retained.
- LOCK:
  - pwm_en=0, lockout=1.
  - clr & !flt -> IDLE, lockout<=0, retry_cnt<=0, first_flt<=0.
  - clr while flt -> ignored, stay in LOCK.
  - start is ignored.
- Width rules:
  - Timer widths are $clog2 of their terminal value plus 1.
  - retry_cnt never exceeds RETRY_MAX.
  - No counter wraps.
- first_flt changes only on a RUN->TRIP edge, on clr in IDLE, or on exit from LOCK.

Optional Feature:
- Macro PRT_SEQ_FLT_MASK_EN.
- When defined:
  - Adds input flt_mask [N_FLT-1:0] (1 = ignore channel).
  - The effective fault vector is Prt_dly & ~flt_mask. It is used for flt, all transition checks and first_flt capture.
  - Mask changes take effect on the next edge.
- When undefined: the port is absent and all channels are active.

Test Plan (COOL_CYC=20, RETRY_MAX=2, RUN_OK_CYC=50):
- Rst high 3 cycles, then start=1, Prt_dly=0 -> state=RUN, pwm_en=1 on the 1st edge after Rst low; retry_cnt=0.
- In RUN, Prt_dly=4'b0101 for 1 cycle -> next edge state=TRIP, pwm_en=0, first_flt=0101. Following edge state=COOL, retry_cnt=1. RUN re-entered exactly 20 cycles after COOL entry.
- Hold Prt_dly[2]=1 through cool-down end -> stays in COOL. Clear at cycle 35 -> RUN on the next edge.
- Three trips with <50 RUN cycles between them -> 3rd TRIP goes to LOCK, lockout=1, retry_cnt=2. clr with Prt_dly=0001 -> stays LOCK. clr with Prt_dly=0 -> IDLE, all records 0.
- Trip, retry, then 50 fault-free RUN cycles -> retry_cnt returns to 0. A later trip -> COOL, not LOCK.
- Prt_dly=0010 and start falling on the same edge in RUN -> TRIP, not IDLE. Rst asserted in COOL -> IDLE with all outputs at reset values.
